// File: rtl/cnn_pkg.sv
// Shared definitions for the CNN pipeline stages.
//   ARITH_FIXED / ARITH_FLOAT : selectors for the arithmetic used by a stage
//   pool_state_t              : control states of the pooling stages
package cnn_pkg;
  localparam int ARITH_FIXED = 0;
  localparam int ARITH_FLOAT = 1;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    FLUSH,
    DONE
  } pool_state_t;
endpackage

// File: rtl/pool_max_cmp.sv
// Combinational "a greater than b" used by the max-pool stages.
//   i_a, i_b  : operands (DATA_WIDTH bits)
//   o_a_gt_b  : 1 when i_a is strictly greater than i_b
// ARITH_FIXED compares signed two's-complement values.
// ARITH_FLOAT compares IEEE-754 single values as sign/magnitude.
// The float compare treats +0 and -0 as equal. NaN is not handled.
module pool_max_cmp
  import cnn_pkg::*;
#(
  parameter int ARITH_TYPE = ARITH_FIXED,
  parameter int DATA_WIDTH = 32
) (
  input  logic [DATA_WIDTH-1:0] i_a,
  input  logic [DATA_WIDTH-1:0] i_b,
  output logic                  o_a_gt_b
);

  generate
    if (ARITH_TYPE == ARITH_FLOAT) begin : g_float
      logic                  w_sa;
      logic                  w_sb;
      logic [DATA_WIDTH-2:0] w_ma;
      logic [DATA_WIDTH-2:0] w_mb;

      assign w_sa = i_a[DATA_WIDTH-1];
      assign w_sb = i_b[DATA_WIDTH-1];
      assign w_ma = i_a[DATA_WIDTH-2:0];
      assign w_mb = i_b[DATA_WIDTH-2:0];

      always_comb begin
        o_a_gt_b = 1'b0;
        if ((w_ma == '0) && (w_mb == '0)) begin
          // Both zero: the sign bits are ignored.
          o_a_gt_b = 1'b0;
        end else if (w_sa != w_sb) begin
          o_a_gt_b = ~w_sa;
        end else if (!w_sa) begin
          o_a_gt_b = (w_ma > w_mb);
        end else begin
          // Both negative: the smaller magnitude is the larger value.
          o_a_gt_b = (w_ma < w_mb);
        end
      end
    end else begin : g_fixed
      assign o_a_gt_b = ($signed(i_a) > $signed(i_b));
    end
  endgenerate

endmodule

// File: rtl/pool_b2.sv
// 2x2 stride-2 max-pool stage after conv block 2 (10x10x16 -> 5x5x16).
// Reads one input word per cycle, reduces each 2x2 window and writes one
// pooled word into the next layer's IFM memory.
//   clk, reset                 : clock, synchronous active-high reset
//   start_from_previous        : input volume ready (pulse)
//   end_to_previous            : last read issued (pulse)
//   ifm_enable_read_current    : read strobe, data returns one cycle later
//   ifm_sel_current            : channel being read
//   ifm_address_read_current   : row*IFM_SIZE+col inside that channel
//   data_in_from_previous      : read data
//   end_from_next              : next layer released our output buffer (pulse)
//   ifm_enable_write_next      : write strobe
//   ifm_sel_next               : channel being written
//   ifm_address_write_next     : r*OFM_SIZE+c
//   data_out_for_next          : pooled value
//   start_to_next              : pooled volume complete (pulse)
module pool_b2
  import cnn_pkg::*;
#(
  parameter  int ARITH_TYPE       = ARITH_FIXED,
  parameter  int DATA_WIDTH       = 32,
  parameter  int IFM_SIZE         = 10,
  parameter  int IFM_DEPTH        = 16,
  localparam int OFM_SIZE         = IFM_SIZE / 2,
  localparam int ADDRESS_SIZE_IFM = $clog2(IFM_SIZE * IFM_SIZE),
  localparam int ADDRESS_SIZE_OFM = $clog2(OFM_SIZE * OFM_SIZE),
  localparam int SEL_BITS         = $clog2(IFM_DEPTH)
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        start_from_previous,
  output logic                        end_to_previous,
  output logic                        ifm_enable_read_current,
  output logic [SEL_BITS-1:0]         ifm_sel_current,
  output logic [ADDRESS_SIZE_IFM-1:0] ifm_address_read_current,
  input  logic [DATA_WIDTH-1:0]       data_in_from_previous,
  input  logic                        end_from_next,
  output logic                        ifm_enable_write_next,
  output logic [SEL_BITS-1:0]         ifm_sel_next,
  output logic [ADDRESS_SIZE_OFM-1:0] ifm_address_write_next,
  output logic [DATA_WIDTH-1:0]       data_out_for_next,
  output logic                        start_to_next
);

  localparam int RC_BITS = (OFM_SIZE > 1) ? $clog2(OFM_SIZE) : 1;
  localparam logic [RC_BITS-1:0]  LAST_RC  = RC_BITS'(OFM_SIZE - 1);
  localparam logic [SEL_BITS-1:0] LAST_SEL = SEL_BITS'(IFM_DEPTH - 1);

  pool_state_t r_state;
  pool_state_t w_state_next;

  // Read-side window counters and the position inside the window.
  logic [1:0]            r_phase;
  logic [RC_BITS-1:0]    r_row;
  logic [RC_BITS-1:0]    r_col;
  logic [SEL_BITS-1:0]   r_sel;
  logic                  r_pending;
  logic                  r_next_free;

  // Same fields delayed one cycle, aligned with the returning read data.
  logic                  r_dvalid;
  logic [1:0]            r_dphase;
  logic [RC_BITS-1:0]    r_drow;
  logic [RC_BITS-1:0]    r_dcol;
  logic [SEL_BITS-1:0]   r_dsel;

  logic [DATA_WIDTH-1:0]       r_max;
  logic                        r_wr_en;
  logic [SEL_BITS-1:0]         r_wr_sel;
  logic [ADDRESS_SIZE_OFM-1:0] r_wr_addr;
  logic [DATA_WIDTH-1:0]       r_wr_data;
  logic                        r_end_prev;

  logic                  w_free;
  logic                  w_accept;
  logic                  w_last_read;
  logic                  w_gt;
  logic [DATA_WIDTH-1:0] w_max_next;
  logic [RC_BITS:0]      w_rd_row;
  logic [RC_BITS:0]      w_rd_col;

  pool_max_cmp #(
    .ARITH_TYPE(ARITH_TYPE),
    .DATA_WIDTH(DATA_WIDTH)
  ) u_cmp (
    .i_a     (data_in_from_previous),
    .i_b     (r_max),
    .o_a_gt_b(w_gt)
  );

  // An end_from_next arriving with a start is honoured in the same cycle.
  assign w_free      = r_next_free | end_from_next;
  assign w_accept    = (r_state == IDLE) && (r_pending || start_from_previous) && w_free;
  assign w_last_read = (r_state == RUN) && (r_phase == 2'd3) && (r_col == LAST_RC)
                       && (r_row == LAST_RC) && (r_sel == LAST_SEL);

  // Phase bit 1 selects the lower row, bit 0 the right column of the window.
  assign w_rd_row = {r_row, r_phase[1]};
  assign w_rd_col = {r_col, r_phase[0]};

  // Phase 0 data always loads; later phases load only when strictly greater,
  // so ties keep the earlier value.
  assign w_max_next = ((r_dphase == 2'd0) || w_gt) ? data_in_from_previous : r_max;

  assign ifm_enable_read_current  = (r_state == RUN);
  assign ifm_sel_current          = r_sel;
  assign ifm_address_read_current = ADDRESS_SIZE_IFM'(int'(w_rd_row) * IFM_SIZE + int'(w_rd_col));
  assign end_to_previous          = r_end_prev;
  assign ifm_enable_write_next    = r_wr_en;
  assign ifm_sel_next             = r_wr_sel;
  assign ifm_address_write_next   = r_wr_addr;
  assign data_out_for_next        = r_wr_data;
  assign start_to_next            = (r_state == DONE);

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      IDLE:    if (w_accept) w_state_next = RUN;
      RUN:     if (w_last_read) w_state_next = FLUSH;
      // Only the final write of the pass happens while flushing.
      FLUSH:   if (r_wr_en) w_state_next = DONE;
      DONE:    w_state_next = IDLE;
      default: w_state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state     <= IDLE;
      r_phase     <= '0;
      r_row       <= '0;
      r_col       <= '0;
      r_sel       <= '0;
      r_pending   <= 1'b0;
      r_next_free <= 1'b1;
      r_dvalid    <= 1'b0;
      r_dphase    <= '0;
      r_drow      <= '0;
      r_dcol      <= '0;
      r_dsel      <= '0;
      r_max       <= '0;
      r_wr_en     <= 1'b0;
      r_wr_sel    <= '0;
      r_wr_addr   <= '0;
      r_wr_data   <= '0;
      r_end_prev  <= 1'b0;
    end else begin
      r_state    <= w_state_next;
      r_pending  <= w_accept ? 1'b0 : (r_pending | start_from_previous);
      r_end_prev <= w_last_read;

      if (r_state == DONE) begin
        r_next_free <= 1'b0;
      end else if (end_from_next) begin
        r_next_free <= 1'b1;
      end

      if (r_state == RUN) begin
        r_phase <= r_phase + 2'd1;
        if (r_phase == 2'd3) begin
          if (r_col == LAST_RC) begin
            r_col <= '0;
            if (r_row == LAST_RC) begin
              r_row <= '0;
              r_sel <= (r_sel == LAST_SEL) ? '0 : r_sel + SEL_BITS'(1);
            end else begin
              r_row <= r_row + RC_BITS'(1);
            end
          end else begin
            r_col <= r_col + RC_BITS'(1);
          end
        end
      end

      r_dvalid <= (r_state == RUN);
      r_dphase <= r_phase;
      r_drow   <= r_row;
      r_dcol   <= r_col;
      r_dsel   <= r_sel;

      if (r_dvalid) begin
        r_max <= w_max_next;
      end

      // The fourth word of a window completes it; the write goes out next cycle
      // while r_max is already loading the next window.
      r_wr_en <= r_dvalid && (r_dphase == 2'd3);
      if (r_dvalid && (r_dphase == 2'd3)) begin
        r_wr_data <= w_max_next;
        r_wr_sel  <= r_dsel;
        r_wr_addr <= ADDRESS_SIZE_OFM'(int'(r_drow) * OFM_SIZE + int'(r_dcol));
      end
    end
  end

endmodule

// File: tb/tb_pool_b2.sv
// Self-checking bench for pool_b2.
// Two instances share the handshake inputs: index 0 uses fixed-point compare,
// index 1 uses float compare. Each has its own input memory model.
// Expected writes are queued when a pass is set up; a monitor pops them on
// every write strobe. Handshake timing is checked relative to the first
// read-strobe cycle of each pass.
module tb_pool_b2;
  import cnn_pkg::*;

  localparam int IFM_SIZE = 10;
  localparam int IFM_DEPTH = 16;
  localparam int OFM_SIZE = 5;
  localparam int NWIN = OFM_SIZE * OFM_SIZE * IFM_DEPTH;
  localparam int NWORDS = IFM_SIZE * IFM_SIZE * IFM_DEPTH;

  typedef struct packed {
    logic [3:0]  sel;
    logic [4:0]  addr;
    logic [31:0] data;
  } exp_t;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic start = 1'b0;
  logic endn = 1'b0;
  int   cyc = 0;

  logic        rd_en[2];
  logic [3:0]  rd_sel[2];
  logic [6:0]  rd_addr[2];
  logic [31:0] din[2];
  logic        end_prev[2];
  logic        wr_en[2];
  logic [3:0]  wr_sel[2];
  logic [4:0]  wr_addr[2];
  logic [31:0] dout[2];
  logic        stn[2];

  logic [31:0] mem[2][NWORDS];
  exp_t        q0[$];
  exp_t        q1[$];

  int n_cmp = 0;
  int n_fail = 0;

  int t_rise[2], n_rd[2], wr_cnt[2], t_first_wr[2], t_last_wr[2];
  int t_end[2], n_end[2], t_stn[2], n_stn[2];
  logic prev_rd[2] = '{1'b0, 1'b0};
  logic [31:0] wlog[2][2];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  pool_b2 #(.ARITH_TYPE(ARITH_FIXED), .DATA_WIDTH(32), .IFM_SIZE(IFM_SIZE), .IFM_DEPTH(IFM_DEPTH)) dut_fix (
    .clk(clk), .reset(reset), .start_from_previous(start), .end_to_previous(end_prev[0]),
    .ifm_enable_read_current(rd_en[0]), .ifm_sel_current(rd_sel[0]),
    .ifm_address_read_current(rd_addr[0]), .data_in_from_previous(din[0]),
    .end_from_next(endn), .ifm_enable_write_next(wr_en[0]), .ifm_sel_next(wr_sel[0]),
    .ifm_address_write_next(wr_addr[0]), .data_out_for_next(dout[0]), .start_to_next(stn[0])
  );

  pool_b2 #(.ARITH_TYPE(ARITH_FLOAT), .DATA_WIDTH(32), .IFM_SIZE(IFM_SIZE), .IFM_DEPTH(IFM_DEPTH)) dut_flt (
    .clk(clk), .reset(reset), .start_from_previous(start), .end_to_previous(end_prev[1]),
    .ifm_enable_read_current(rd_en[1]), .ifm_sel_current(rd_sel[1]),
    .ifm_address_read_current(rd_addr[1]), .data_in_from_previous(din[1]),
    .end_from_next(endn), .ifm_enable_write_next(wr_en[1]), .ifm_sel_next(wr_sel[1]),
    .ifm_address_write_next(wr_addr[1]), .data_out_for_next(dout[1]), .start_to_next(stn[1])
  );

  // Conv-2 output memory: registered read, data one cycle after the strobe.
  always @(posedge clk) begin
    for (int d = 0; d < 2; d++) begin
      if (rd_en[d]) din[d] <= mem[d][int'(rd_sel[d]) * 100 + int'(rd_addr[d])];
    end
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Numeric ordering key: signed integer, or the real value's order for floats.
  function automatic longint key(input int d, input logic [31:0] w);
    longint mag;
    if (d == 0) return longint'($signed(w));
    mag = longint'(w[30:0]);
    if (mag == 0) return 0;
    return w[31] ? -mag : mag;
  endfunction

  task automatic push_expected();
    logic [31:0] best, v;
    int base;
    exp_t e;
    for (int d = 0; d < 2; d++) begin
      for (int ch = 0; ch < IFM_DEPTH; ch++) begin
        for (int r = 0; r < OFM_SIZE; r++) begin
          for (int c = 0; c < OFM_SIZE; c++) begin
            base = ch * 100 + (2 * r) * IFM_SIZE + 2 * c;
            best = mem[d][base];
            for (int k = 1; k < 4; k++) begin
              v = mem[d][base + (k / 2) * IFM_SIZE + (k % 2)];
              if (key(d, v) > key(d, best)) best = v;
            end
            e.sel = 4'(ch);
            e.addr = 5'(r * OFM_SIZE + c);
            e.data = best;
            if (d == 0) q0.push_back(e);
            else q1.push_back(e);
          end
        end
      end
    end
  endtask

  function automatic logic [31:0] rand_float();
    logic [31:0] m;
    logic [7:0] e;
    logic s;
    s = 1'($urandom_range(0, 1));
    e = 8'($urandom_range(0, 254));
    m = $urandom;
    if ($urandom_range(0, 7) == 0) return {s, 31'b0};
    return {s, e, m[22:0]};
  endfunction

  task automatic load_pattern();
    for (int i = 0; i < NWORDS; i++) begin
      mem[0][i] = 32'(i);
      mem[1][i] = 32'(i);
    end
  endtask

  task automatic load_random();
    for (int i = 0; i < NWORDS; i++) begin
      if ($urandom_range(0, 3) == 0) mem[0][i] = 32'($signed($urandom_range(0, 8)) - 4);
      else mem[0][i] = $urandom;
      mem[1][i] = rand_float();
    end
  endtask

  task automatic clear_stats();
    for (int d = 0; d < 2; d++) begin
      t_rise[d] = -1; n_rd[d] = 0; wr_cnt[d] = 0; t_first_wr[d] = -1; t_last_wr[d] = -1;
      t_end[d] = -1; n_end[d] = 0; t_stn[d] = -1; n_stn[d] = 0;
    end
  endtask

  function automatic logic [55:0] outs(input int d);
    return {rd_en[d], rd_sel[d], rd_addr[d], end_prev[d], wr_en[d], wr_sel[d],
            wr_addr[d], dout[d], stn[d]};
  endfunction

  task automatic mon_write(input int d);
    exp_t act, e;
    act = {wr_sel[d], wr_addr[d], dout[d]};
    $display("[%0d] dut%0d write sel=%0d addr=%0d data=%08h", cyc, d, wr_sel[d], wr_addr[d], dout[d]);
    if ((d == 0 && q0.size() == 0) || (d == 1 && q1.size() == 0)) begin
      check($sformatf("dut%0d_unexpected_write", d), 64'(act), 64'h1_0000_0000_0000);
    end else begin
      e = (d == 0) ? q0.pop_front() : q1.pop_front();
      check($sformatf("dut%0d_write", d), 64'(act), 64'(e));
    end
  endtask

  always @(negedge clk) begin
    for (int d = 0; d < 2; d++) begin
      if (rd_en[d]) begin
        n_rd[d]++;
        if (!prev_rd[d] && t_rise[d] < 0) t_rise[d] = cyc;
      end
      prev_rd[d] = rd_en[d];
      if (end_prev[d]) begin n_end[d]++; t_end[d] = cyc; end
      if (stn[d]) begin n_stn[d]++; t_stn[d] = cyc; end
      if (wr_en[d]) begin
        if (wr_cnt[d] == 0) t_first_wr[d] = cyc;
        t_last_wr[d] = cyc;
        if (wr_cnt[d] < 2) wlog[d][wr_cnt[d]] = dout[d];
        wr_cnt[d]++;
        mon_write(d);
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic pulse_start(output int t);
    @(posedge clk); #1;
    start = 1'b1; t = cyc;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic pulse_end(output int t);
    @(posedge clk); #1;
    endn = 1'b1; t = cyc;
    @(posedge clk); #1;
    endn = 1'b0;
  endtask

  task automatic wait_cycle(input int target);
    while (cyc < target) begin @(posedge clk); #1; end
  endtask

  task automatic wait_done(input int budget);
    int i = 0;
    while (n_stn[0] == 0 && i < budget) begin @(posedge clk); i++; end
    #1;
    check("pass_completed", 64'(n_stn[0] > 0), 64'd1);
    tick(3);
  endtask

  task automatic check_pass(input int rise_exp, input string tag);
    for (int d = 0; d < 2; d++) begin
      check($sformatf("%s_dut%0d_read_rise", tag, d), 64'(t_rise[d]), 64'(rise_exp));
      check($sformatf("%s_dut%0d_first_write", tag, d), 64'(t_first_wr[d] - rise_exp), 64'd5);
      check($sformatf("%s_dut%0d_end_prev_cycle", tag, d), 64'(t_end[d] - rise_exp), 64'd1600);
      check($sformatf("%s_dut%0d_last_write", tag, d), 64'(t_last_wr[d] - rise_exp), 64'd1601);
      check($sformatf("%s_dut%0d_start_next_cycle", tag, d), 64'(t_stn[d] - rise_exp), 64'd1602);
      check($sformatf("%s_dut%0d_end_prev_count", tag, d), 64'(n_end[d]), 64'd1);
      check($sformatf("%s_dut%0d_start_next_count", tag, d), 64'(n_stn[d]), 64'd1);
      check($sformatf("%s_dut%0d_write_count", tag, d), 64'(wr_cnt[d]), 64'(NWIN));
      check($sformatf("%s_dut%0d_read_cycles", tag, d), 64'(n_rd[d]), 64'(4 * NWIN));
    end
    check($sformatf("%s_queue0_drained", tag), 64'(q0.size()), 64'd0);
    check($sformatf("%s_queue1_drained", tag), 64'(q1.size()), 64'd0);
  endtask

  initial begin
    int ts, te, bad;
    clear_stats();

    // Reset state.
    tick(3);
    @(negedge clk);
    check("reset_outputs_dut0", outs(0), 56'd0);
    check("reset_outputs_dut1", outs(1), 56'd0);
    @(posedge clk); #1;
    reset = 1'b0;
    tick(2);

    // Pass A: pattern volume with hand-picked first windows.
    load_pattern();
    mem[0][0] = 32'd3; mem[0][1] = -32'sd7; mem[0][10] = 32'd12; mem[0][11] = 32'd5;
    mem[1][0] = 32'hBF800000; mem[1][1] = 32'hBF000000;
    mem[1][10] = 32'hC0000000; mem[1][11] = 32'hC0400000;
    mem[1][2] = 32'h80000000; mem[1][3] = 32'h00000000;
    mem[1][12] = 32'h80000000; mem[1][13] = 32'h80000000;
    push_expected();
    clear_stats();
    pulse_start(ts);
    wait_done(2000);
    check_pass(ts + 1, "passA");
    check("fixed_window0_max", 64'(wlog[0][0]), 64'd12);
    check("float_negatives_max", 64'(wlog[1][0]), 64'hBF000000);
    check("float_signed_zero_tie", 64'(wlog[1][1]), 64'h80000000);

    // Pass B: start while the next layer still holds our buffer.
    load_random();
    clear_stats();
    pulse_start(ts);
    tick(30);
    check("blocked_start_no_read", 64'(n_rd[0]), 64'd0);
    push_expected();
    pulse_end(te);
    // Start during the pass (RUN cycle 300) must be remembered.
    wait_cycle(te + 1 + 300);
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    wait_done(2000);
    check_pass(te + 1, "passB");

    // Pass C: the remembered start waits for end_from_next.
    clear_stats();
    tick(20);
    check("pending_waits_for_free", 64'(n_rd[0]), 64'd0);
    load_pattern();
    push_expected();
    pulse_end(te);
    wait_done(2000);
    check_pass(te + 1, "passC");

    // Pass D: reset in the middle of a pass.
    pulse_end(te);
    tick(2);
    load_pattern();
    push_expected();
    clear_stats();
    pulse_start(ts);
    wait_cycle(ts + 1 + 700);
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    bad = 0;
    repeat (10) begin
      @(negedge clk);
      if (outs(0) != 56'd0 || outs(1) != 56'd0) bad++;
    end
    check("abort_outputs_zero", 64'(bad), 64'd0);
    check("abort_no_end_prev", 64'(n_end[0] + n_end[1]), 64'd0);
    check("abort_no_start_next", 64'(n_stn[0] + n_stn[1]), 64'd0);
    check("abort_write_count", 64'(wr_cnt[0]), 64'd174);
    check("abort_queue_left", 64'(q0.size()), 64'(NWIN - 174));
    q0.delete();
    q1.delete();

    // Pass E: restart after the abort reproduces the pattern result.
    push_expected();
    clear_stats();
    pulse_start(ts);
    wait_done(2000);
    check_pass(ts + 1, "passE");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
